inv_pipe_elastic: RTL and testbench

- Parametrised successor to the fixed single-bit flop/inverter chain.
- An N-stage, W-bit register pipeline with a per-stage inversion mask and valid/ready backpressure. Stalls do not lose data, and bubbles collapse.
- Adds synchronous flush, an occupancy count and a saturating transfer counter.
- Sits between a registered launch point and a downstream consumer in the Nangate45 timing test designs. Intended as a depth/width-scalable TNS/STA exerciser.

---
 rtl/inv_pipe_elastic.sv | 97 +++++++++
 tb/tb_inv_pipe_elastic.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/inv_pipe_elastic.sv
// inv_pipe_elastic: N-stage, W-bit elastic register pipeline with a per-stage
// inversion mask, valid/ready backpressure, bubble collapse, synchronous flush,
// an occupancy counter and a saturating output-handshake counter.
module inv_pipe_elastic #(
  parameter int unsigned             WIDTH    = 1,
  parameter int unsigned             DEPTH    = 3,
  parameter logic [DEPTH-1:0]        INV_MASK = 3'b110,
  parameter int unsigned             CNT_W    = 16,
  localparam int unsigned            OCC_W    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [OCC_W-1:0] occupancy,
  output logic [CNT_W-1:0] xfer_count
);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] ld;
  logic [OCC_W-1:0] occ_q;
  logic [CNT_W-1:0] xfer_q;

  // Walk from the output back to the input: a stage advances when it is valid
  // and the stage after it is either empty or itself advancing. The running
  // "room downstream" flag avoids a self-referencing vector.
  always_comb begin
    logic room;
    room = out_ready;
    adv  = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      adv[k] = vld_q[k] & room;
      room   = ~vld_q[k] | adv[k];
    end
    in_ready = room;
    ld       = '0;
    ld[0]    = in_valid & room;
    for (int k = 1; k < DEPTH; k++) begin
      ld[k] = adv[k - 1];
    end
  end

  // Stage registers, occupancy and transfer counter; flush clears valids but
  // leaves the data registers untouched, and still lets the output handshake count.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q  <= '0;
      occ_q  <= '0;
      xfer_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      if (!flush) begin
        if (ld[0]) begin
          data_q[0] <= in_data ^ {WIDTH{INV_MASK[0]}};
        end
        for (int k = 1; k < DEPTH; k++) begin
          if (ld[k]) begin
            data_q[k] <= data_q[k - 1] ^ {WIDTH{INV_MASK[k]}};
          end
        end
        for (int k = 0; k < DEPTH; k++) begin
          if (ld[k]) begin
            vld_q[k] <= 1'b1;
          end else if (adv[k]) begin
            vld_q[k] <= 1'b0;
          end
        end
        if (ld[0] && !adv[DEPTH - 1]) begin
          occ_q <= occ_q + OCC_W'(1);
        end else if (!ld[0] && adv[DEPTH - 1]) begin
          occ_q <= occ_q - OCC_W'(1);
        end
      end else begin
        vld_q <= '0;
        occ_q <= '0;
      end
      if (adv[DEPTH - 1] && (xfer_q != {CNT_W{1'b1}})) begin
        xfer_q <= xfer_q + CNT_W'(1);
      end
    end
  end

  assign out_data   = data_q[DEPTH - 1];
  assign out_valid  = vld_q[DEPTH - 1];
  assign occupancy  = occ_q;
  assign xfer_count = xfer_q;

endmodule

// File: tb/tb_inv_pipe_elastic.sv
// Self-checking bench for inv_pipe_elastic: three instances (defaults, an
// 8-bit/4-deep variant, and a 3-bit transfer counter variant) exercised by
// per-scenario tasks with a queue scoreboard of expected output words.
module tb_inv_pipe_elastic;

  localparam logic [2:0] M0 = 3'b110;
  localparam logic [3:0] M1 = 4'b0001;

  logic clk = 1'b0;
  logic reset;

  logic       iv0, ir0, or0, ov0, fl0, id0, od0;
  logic [1:0] occ0;
  logic [15:0] xc0;

  logic       iv1, ir1, or1, ov1, fl1;
  logic [7:0] id1, od1;
  logic [2:0] occ1;
  logic [15:0] xc1;

  logic       iv2, ir2, or2, ov2, fl2, id2, od2;
  logic [1:0] occ2;
  logic [2:0] xc2;

  logic [7:0] sb[$];
  logic [7:0] expv;
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  inv_pipe_elastic dut0 (
    .clk(clk), .reset(reset), .in_valid(iv0), .in_ready(ir0), .in_data(id0),
    .out_valid(ov0), .out_ready(or0), .out_data(od0), .flush(fl0),
    .occupancy(occ0), .xfer_count(xc0)
  );

  inv_pipe_elastic #(.WIDTH(8), .DEPTH(4), .INV_MASK(M1), .CNT_W(16)) dut1 (
    .clk(clk), .reset(reset), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1), .flush(fl1),
    .occupancy(occ1), .xfer_count(xc1)
  );

  inv_pipe_elastic #(.CNT_W(3)) dut2 (
    .clk(clk), .reset(reset), .in_valid(iv2), .in_ready(ir2), .in_data(id2),
    .out_valid(ov2), .out_ready(or2), .out_data(od2), .flush(fl2),
    .occupancy(occ2), .xfer_count(xc2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    checks++; if (ov0 !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid got=%0b exp=0", ov0); end
    checks++; if (od0 !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_data got=%0b exp=0", od0); end
    checks++; if (occ0 !== 2'd0) begin failures++; $display("[TB] FAIL reset_occupancy got=%0d exp=0", occ0); end
    checks++; if (xc0 !== 16'd0) begin failures++; $display("[TB] FAIL reset_xfer_count got=%0d exp=0", xc0); end
    checks++; if (ir0 !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready got=%0b exp=1", ir0); end
  endtask

  task automatic test_latency();
    iv0 = 1'b1; id0 = 1'b1; or0 = 1'b1;
    tick();
    iv0 = 1'b0; id0 = 1'b0;
    checks++; if (occ0 !== 2'd1 || ov0 !== 1'b0) begin failures++; $display("[TB] FAIL lat_c1 occ=%0d ov=%0b exp occ=1 ov=0", occ0, ov0); end
    tick();
    checks++; if (occ0 !== 2'd1 || ov0 !== 1'b0) begin failures++; $display("[TB] FAIL lat_c2 occ=%0d ov=%0b exp occ=1 ov=0", occ0, ov0); end
    tick();
    checks++; if (ov0 !== 1'b1 || od0 !== 1'b1 || occ0 !== 2'd1) begin failures++; $display("[TB] FAIL lat_c3 ov=%0b od=%0b occ=%0d exp 1,1,1", ov0, od0, occ0); end
    tick();
    checks++; if (ov0 !== 1'b0 || occ0 !== 2'd0 || xc0 !== 16'd1) begin failures++; $display("[TB] FAIL lat_c4 ov=%0b occ=%0d xc=%0d exp 0,0,1", ov0, occ0, xc0); end
  endtask

  task automatic test_stall();
    int acc = 0, first_block = -1, gaps = 0, outs = 0;
    sb.delete();
    or0 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      iv0 = 1'b1; id0 = i[0];
      @(negedge clk);
      if (ir0) begin sb.push_back({7'd0, id0 ^ (^M0)}); acc++; end
      else if (first_block < 0) first_block = i;
      tick();
    end
    checks++; if (acc != 3) begin failures++; $display("[TB] FAIL stall_accepted got=%0d exp=3", acc); end
    checks++; if (first_block != 3) begin failures++; $display("[TB] FAIL stall_block_cycle got=%0d exp=3", first_block); end
    checks++; if (occ0 !== 2'd3) begin failures++; $display("[TB] FAIL stall_occupancy got=%0d exp=3", occ0); end
    checks++; if (ir0 !== 1'b0) begin failures++; $display("[TB] FAIL stall_in_ready got=%0b exp=0", ir0); end
    or0 = 1'b1;
    for (int i = 0; i < 9; i++) begin
      iv0 = (i < 6); id0 = i[1];
      @(negedge clk);
      if (iv0 && ir0) sb.push_back({7'd0, id0 ^ (^M0)});
      if (ov0) begin
        outs++;
        checks++;
        if (sb.size() == 0) begin failures++; $display("[TB] FAIL stall_unexpected_out got=%0b exp=none", od0); end
        else begin
          expv = sb.pop_front();
          if (od0 !== expv[0]) begin failures++; $display("[TB] FAIL stall_data got=%0b exp=%0b", od0, expv[0]); end
        end
      end else gaps++;
      tick();
    end
    iv0 = 1'b0;
    checks++; if (gaps != 0 || outs != 9) begin failures++; $display("[TB] FAIL stall_drain gaps=%0d outs=%0d exp gaps=0 outs=9", gaps, outs); end
    checks++; if (sb.size() != 0) begin failures++; $display("[TB] FAIL stall_leftover got=%0d exp=0", sb.size()); end
  endtask

  task automatic test_flush();
    logic [15:0] xprev;
    int seen = 0;
    or0 = 1'b0; iv0 = 1'b1; id0 = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    checks++; if (occ0 !== 2'd3) begin failures++; $display("[TB] FAIL flush_fill got=%0d exp=3", occ0); end
    xprev = xc0;
    fl0 = 1'b1; iv0 = 1'b1; id0 = 1'b1;
    tick();
    fl0 = 1'b0; iv0 = 1'b0;
    checks++; if (ov0 !== 1'b0 || occ0 !== 2'd0) begin failures++; $display("[TB] FAIL flush_clear ov=%0b occ=%0d exp 0,0", ov0, occ0); end
    checks++; if (xc0 !== xprev) begin failures++; $display("[TB] FAIL flush_xfer_hold got=%0d exp=%0d", xc0, xprev); end
    checks++; if (ir0 !== 1'b1) begin failures++; $display("[TB] FAIL flush_in_ready got=%0b exp=1", ir0); end
    or0 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ov0) seen++;
      tick();
    end
    checks++; if (seen != 0) begin failures++; $display("[TB] FAIL flush_ghost_out got=%0d exp=0", seen); end
    or0 = 1'b0; iv0 = 1'b1; id0 = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    xprev = xc0;
    fl0 = 1'b1; or0 = 1'b1;
    tick();
    fl0 = 1'b0; iv0 = 1'b0;
    checks++; if (xc0 !== 16'(xprev + 16'd1)) begin failures++; $display("[TB] FAIL flush_xfer_count got=%0d exp=%0d", xc0, xprev + 16'd1); end
    checks++; if (occ0 !== 2'd0 || ov0 !== 1'b0) begin failures++; $display("[TB] FAIL flush_out_clear occ=%0d ov=%0b exp 0,0", occ0, ov0); end
  endtask

  task automatic test_back_to_back();
    int first = -1, last = -1, outs = 0;
    sb.delete();
    or1 = 1'b1;
    for (int c = 0; c < 30; c++) begin
      iv1 = (c < 16); id1 = 8'(c);
      @(negedge clk);
      if (iv1 && ir1) sb.push_back(id1 ^ {8{^M1}});
      if (ov1) begin
        if (first < 0) first = c;
        last = c; outs++;
        checks++;
        if (sb.size() == 0) begin failures++; $display("[TB] FAIL b2b_unexpected_out got=%02h exp=none", od1); end
        else begin
          expv = sb.pop_front();
          if (od1 !== expv) begin failures++; $display("[TB] FAIL b2b_data got=%02h exp=%02h", od1, expv); end
        end
      end
      tick();
    end
    iv1 = 1'b0;
    checks++; if (first != 4 || last != 19) begin failures++; $display("[TB] FAIL b2b_timing first=%0d last=%0d exp 4,19", first, last); end
    checks++; if (outs != 16) begin failures++; $display("[TB] FAIL b2b_count got=%0d exp=16", outs); end
    checks++; if (xc1 !== 16'd16) begin failures++; $display("[TB] FAIL b2b_xfer_count got=%0d exp=16", xc1); end
  endtask

  task automatic test_saturation();
    int outs = 0;
    sb.delete();
    or2 = 1'b1;
    for (int c = 0; c < 26; c++) begin
      iv2 = (c < 10) || (c >= 18 && c < 21); id2 = c[0];
      @(negedge clk);
      if (iv2 && ir2) sb.push_back({7'd0, id2 ^ (^M0)});
      if (ov2) begin
        outs++;
        checks++;
        if (sb.size() == 0) begin failures++; $display("[TB] FAIL sat_unexpected_out got=%0b exp=none", od2); end
        else begin
          expv = sb.pop_front();
          if (od2 !== expv[0]) begin failures++; $display("[TB] FAIL sat_data got=%0b exp=%0b", od2, expv[0]); end
        end
      end
      tick();
      if (c == 16) begin
        checks++; if (xc2 !== 3'd7 || outs != 10) begin failures++; $display("[TB] FAIL sat_count xc=%0d outs=%0d exp 7,10", xc2, outs); end
      end
    end
    iv2 = 1'b0;
    checks++; if (xc2 !== 3'd7 || outs != 13) begin failures++; $display("[TB] FAIL sat_hold xc=%0d outs=%0d exp 7,13", xc2, outs); end
  endtask

  task automatic test_reset_midstream();
    or0 = 1'b0; iv0 = 1'b1; id0 = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    or0 = 1'b1; iv0 = 1'b0;
    tick();
    checks++; if (occ0 !== 2'd2 || od0 !== 1'b1) begin failures++; $display("[TB] FAIL mid_pre occ=%0d od=%0b exp 2,1", occ0, od0); end
    reset = 1'b1; iv0 = 1'b1;
    tick();
    checks++; if (ov0 !== 1'b0 || od0 !== 1'b0) begin failures++; $display("[TB] FAIL mid_out ov=%0b od=%0b exp 0,0", ov0, od0); end
    checks++; if (occ0 !== 2'd0 || xc0 !== 16'd0) begin failures++; $display("[TB] FAIL mid_counts occ=%0d xc=%0d exp 0,0", occ0, xc0); end
    reset = 1'b0; iv0 = 1'b0;
    #1;
    checks++; if (ir0 !== 1'b1) begin failures++; $display("[TB] FAIL mid_in_ready got=%0b exp=1", ir0); end
  endtask

  initial begin
    reset = 1'b1;
    iv0 = 1'b0; id0 = 1'b0; or0 = 1'b0; fl0 = 1'b0;
    iv1 = 1'b0; id1 = 8'd0; or1 = 1'b0; fl1 = 1'b0;
    iv2 = 1'b0; id2 = 1'b0; or2 = 1'b0; fl2 = 1'b0;
    $display("[TB] starting inv_pipe_elastic bench");
    test_reset();
    test_latency();
    test_stall();
    test_flush();
    test_back_to_back();
    test_saturation();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
